// File: rtl/fp32_pkg.sv
// fp32_pkg: shared constants and types for the sequential FP32 divider.
//   - IEEE-754 single field widths, exponent bias and saturation limit
//   - quotient/remainder/mantissa widths of the restoring divider
//   - canonical quiet NaN and +Inf encodings
//   - controller state enum
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 1;    // mantissa with hidden one
    localparam int REM_W  = MANT_W + 1;    // remainder needs one headroom bit
    localparam int QUOT_W = 27;            // 1 integer + 23 frac + guard + 2 extra
    localparam int BIAS   = 127;
    localparam int EXP_MAX = 255;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PREP   = 3'd1,
        DIVIDE = 3'd2,
        NORM   = 3'd3,
        DONE   = 3'd4
    } state_e;

endpackage

// File: rtl/mant_div_step.sv
// mant_div_step: one restoring-division iteration (combinational).
//   rem_i : current partial remainder
//   div_i : divisor mantissa (zero-extended)
//   rem_o : next partial remainder, already shifted left for the next bit
//   q_o   : quotient bit produced by this iteration
module mant_div_step
    import fp32_pkg::*;
(
    input  logic [REM_W-1:0] rem_i,
    input  logic [REM_W-1:0] div_i,
    output logic [REM_W-1:0] rem_o,
    output logic             q_o
);

    logic [REM_W:0]   diff;
    logic [REM_W-1:0] kept;

    always_comb begin
        diff  = {1'b0, rem_i} - {1'b0, div_i};
        // No borrow means the divisor fits: emit a one and keep the difference.
        q_o   = ~diff[REM_W];
        kept  = q_o ? diff[REM_W-1:0] : rem_i;
        // kept < divisor < 2^24, so the shift never loses a set bit.
        rem_o = kept << 1;
    end

endmodule

// File: rtl/fp32_divider_seq.sv
// fp32_divider_seq: multi-cycle IEEE-754 single-precision divider.
//   clk     : clock, all state updates on rising edge
//   rst     : synchronous active-high reset, aborts any operation
//   start   : request, sampled only in IDLE
//   number1 : dividend, captured on the accepted start
//   number2 : divisor, captured on the accepted start
//   busy    : high from the edge after an accepted start through the DONE cycle
//   done    : one-cycle pulse when result holds the new quotient
//   result  : quotient, held until the next result write
//   state_o : current controller state, for observation only
//
// Handshake: a request is taken when start=1 while busy=0 (IDLE); start is
// ignored at all other times. done=1 marks the single cycle in which result
// is newly valid; busy is also high in that cycle and drops the cycle after.
//
// Flush-to-zero: denormal inputs read as signed zero, tiny results become
// signed zero. Rounding is round-to-nearest, ties-to-even.
module fp32_divider_seq
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] number1,
    input  logic [31:0] number2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output state_e      state_o
);

    state_e state_q, state_d;

    logic [31:0]        a_q, b_q;          // captured operands
    logic               sign_q;
    logic signed [9:0]  exp_q;             // biased quotient exponent, signed
    logic [REM_W-1:0]   rem_q, div_q;
    logic [QUOT_W-1:0]  quo_q;
    logic [4:0]         cnt_q;
    logic               spec_q;            // special result staged in PREP
    logic [31:0]        spec_res_q;
    logic [31:0]        result_q;

    // ---------------- operand decode (from captured operands) ----------------
    logic [EXP_W-1:0]  ea, eb;
    logic [FRAC_W-1:0] fa, fb;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic              sign_p, is_special;
    logic [31:0]       special_res;
    logic signed [9:0] exp_p;

    always_comb begin
        ea     = a_q[30:23];
        eb     = b_q[30:23];
        fa     = a_q[22:0];
        fb     = b_q[22:0];
        sign_p = a_q[31] ^ b_q[31];
        // Exponent field zero covers both true zero and denormals.
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (fa == '0);
        b_inf  = (eb == '1) && (fb == '0);
        a_nan  = (ea == '1) && (fa != '0);
        b_nan  = (eb == '1) && (fb != '0);
        exp_p  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;

        is_special  = 1'b1;
        special_res = QNAN;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            special_res = QNAN;
        end else if (a_inf || b_zero) begin
            special_res = {sign_p, POS_INF[30:0]};
        end else if (a_zero || b_inf) begin
            special_res = {sign_p, 31'h0};
        end else begin
            is_special = 1'b0;
        end
    end

    // ---------------- divider iteration ----------------
    logic [REM_W-1:0] step_rem;
    logic             step_q;

    mant_div_step u_step (
        .rem_i (rem_q),
        .div_i (div_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    // ---------------- normalise and round ----------------
    logic [FRAC_W-1:0] frac_t;
    logic [FRAC_W:0]   frac_r;
    logic              guard, sticky, round_up;
    logic signed [9:0] exp_t;
    logic [31:0]       norm_res;

    always_comb begin
        if (quo_q[QUOT_W-1]) begin
            frac_t = quo_q[25:3];
            guard  = quo_q[2];
            sticky = quo_q[1] | quo_q[0] | (|rem_q);
            exp_t  = exp_q;
        end else begin
            // Quotient in [0.5,1): leading one sits one place lower.
            frac_t = quo_q[24:2];
            guard  = quo_q[1];
            sticky = quo_q[0] | (|rem_q);
            exp_t  = exp_q - 10'sd1;
        end
        round_up = guard & (sticky | frac_t[0]);
        frac_r   = {1'b0, frac_t} + {{FRAC_W{1'b0}}, round_up};
        // Carry out of the fraction means mantissa 2.0: fraction wraps to 0.
        if (frac_r[FRAC_W]) begin
            exp_t = exp_t + 10'sd1;
        end
        if (exp_t >= 10'sd255) begin
            norm_res = {sign_q, POS_INF[30:0]};
        end else if (exp_t <= 10'sd0) begin
            norm_res = {sign_q, 31'h0};
        end else begin
            norm_res = {sign_q, exp_t[EXP_W-1:0], frac_r[FRAC_W-1:0]};
        end
    end

    // ---------------- controller ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (start) state_d = PREP;
            PREP: begin
                // Special results spend one extra PREP cycle so the result
                // write comes from the staged register.
                if (spec_q)          state_d = DONE;
                else if (!is_special) state_d = DIVIDE;
            end
            DIVIDE: if (cnt_q == 5'(QUOT_W - 1)) state_d = NORM;
            NORM:   state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            rem_q      <= '0;
            div_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            result_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q <= number1;
                        b_q <= number2;
                    end
                end
                PREP: begin
                    sign_q <= sign_p;
                    exp_q  <= exp_p;
                    rem_q  <= {2'b01, fa};
                    div_q  <= {2'b01, fb};
                    quo_q  <= '0;
                    cnt_q  <= '0;
                    if (spec_q) begin
                        result_q <= spec_res_q;
                        spec_q   <= 1'b0;
                    end else begin
                        spec_q     <= is_special;
                        spec_res_q <= special_res;
                    end
                end
                DIVIDE: begin
                    rem_q <= step_rem;
                    quo_q <= {quo_q[QUOT_W-2:0], step_q};
                    cnt_q <= cnt_q + 5'd1;
                end
                NORM: begin
                    result_q <= norm_res;
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign result  = result_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_fp32_divider_seq.sv
// tb_fp32_divider_seq: directed vector table plus hand-written sequences for
// reset abort, start-while-busy, back-to-back and reset/start priority.
module tb_fp32_divider_seq;
    import fp32_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] number1;
    logic [31:0] number2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    state_e      state_o;

    fp32_divider_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .number1 (number1),
        .number2 (number2),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .state_o (state_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int passed = 0;
    int total  = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int overlap_err = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (done) done_cnt++;
            if (done && !busy) overlap_err++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue one operation from a negedge; returns at the negedge of the done
    // cycle, lat = rising edges from the accepting edge to done (-1 on timeout).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        int n;
        number1 = a;
        number2 = b;
        start   = 1'b1;
        @(posedge clk);
        n   = 0;
        lat = -1;
        @(negedge clk);
        start = 1'b0;
        while (lat < 0 && n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) lat = n;
        end
        res = result;
        if (lat >= 0) exp_done++;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

    initial begin
        logic [31:0] res;
        int lat;
        int d0;
        int n;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 29}; // 6/2
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 29}; // 1/3 rounds up
        vecs[2]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 2};  // -1/0
        vecs[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 2};  // 0/0
        vecs[4]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 29}; // overflow
        vecs[5]  = '{32'h00800000, 32'h40000000, 32'h00000000, 29}; // underflow
        vecs[6]  = '{32'h41200000, 32'h40A00000, 32'h40000000, 29}; // 10/5
        vecs[7]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 2};  // NaN in
        vecs[8]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 2};  // Inf/Inf
        vecs[9]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 2};  // Inf/-2
        vecs[10] = '{32'h3F800000, 32'h7F800000, 32'h00000000, 2};  // 1/Inf
        vecs[11] = '{32'h80000000, 32'h40000000, 32'h80000000, 2};  // -0/2
        vecs[12] = '{32'h00400000, 32'h3F800000, 32'h00000000, 2};  // denormal/1
        vecs[13] = '{32'h3F800000, 32'h00400000, 32'h7F800000, 2};  // 1/denormal
        vecs[14] = '{32'hC0400000, 32'h3FC00000, 32'hC0000000, 29}; // -3/1.5
        vecs[15] = '{32'h3F800000, 32'h3F800001, 32'h3F7FFFFE, 29}; // no round
        vecs[16] = '{32'h3F7FFFFF, 32'h3F7FFFFE, 32'h3F800001, 29}; // round up
        vecs[17] = '{32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 29}; // max finite
        vecs[18] = '{32'h00800000, 32'h3F800000, 32'h00800000, 29}; // min normal
        vecs[19] = '{32'h00800000, 32'h3FC00000, 32'h00000000, 29}; // e drops to 0

        // ---------------- reset ----------------
        rst = 1'b1; start = 1'b0; number1 = '0; number2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy",   {31'h0, busy}, 32'h0);
        check("reset done",   {31'h0, done}, 32'h0);
        check("reset result", result, 32'h0);
        check("reset state",  32'(state_o), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        // ---------------- vector table ----------------
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].a, vecs[i].b, res, lat);
            check($sformatf("vec%0d result", i), res, vecs[i].exp);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            @(posedge clk);
            @(negedge clk);
        end

        // ---------------- start while busy is ignored ----------------
        d0 = done_cnt;
        number1 = 32'h3F800000; number2 = 32'h40400000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy after start", {31'h0, busy}, 32'h1);
        repeat (4) @(negedge clk);
        number1 = 32'h40000000; number2 = 32'h40000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("busy-start result", result, 32'h3EAAAAAB);
        repeat (40) @(negedge clk);
        check("busy-start done pulses", 32'(done_cnt - d0), 32'd1);
        exp_done++;

        // ---------------- back-to-back ----------------
        run_op(32'h40C00000, 32'h40000000, res, lat);
        check("b2b first result", res, 32'h40400000);
        @(posedge clk);
        @(negedge clk);
        check("b2b idle between", {31'h0, busy}, 32'h0);
        run_op(32'h41200000, 32'h40A00000, res, lat);
        check("b2b second result", res, 32'h40000000);
        check("b2b second latency", 32'(lat), 32'd29);
        @(posedge clk);
        @(negedge clk);

        // ---------------- reset mid-operation ----------------
        d0 = done_cnt;
        number1 = 32'h40C00000; number2 = 32'h40000000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort busy",   {31'h0, busy}, 32'h0);
        check("abort done",   {31'h0, done}, 32'h0);
        check("abort result", result, 32'h0);
        repeat (40) @(negedge clk);
        check("abort no done pulse", 32'(done_cnt - d0), 32'd0);

        // ---------------- reset beats start ----------------
        rst = 1'b1; start = 1'b1;
        number1 = 32'h40C00000; number2 = 32'h40000000;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst priority busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        check("rst priority state", 32'(state_o), 32'(IDLE));

        // ---------------- global invariants ----------------
        check("done without busy", 32'(overlap_err), 32'd0);
        check("total done pulses", 32'(done_cnt), 32'(exp_done));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard stop in case the stimulus itself stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp32_divider_seq.md
FP32_DIVIDER_SEQ -- requirements
Module: fp32_divider_seq

Interface
REQ-001 clk  input  1  clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 start  input  1  request; sampled only in IDLE.
REQ-004 number1  input  32  IEEE-754 single dividend; captured on the accepted start.
REQ-005 number2  input  32  IEEE-754 single divisor; captured on the accepted start.
REQ-006 busy  output  1  high from the edge after an accepted start until the DONE cycle ends.
REQ-007 done  output  1  one-cycle pulse when result is valid.
REQ-008 result  output  32  quotient number1/number2; holds its value until the next result write.

Function
REQ-009 States SHALL be IDLE, PREP, DIVIDE, NORM and DONE.
REQ-010 Transitions SHALL be: IDLE->PREP on start; PREP->DIVIDE for normal operands; PREP->DONE for special operands; DIVIDE->NORM after 27 iterations; NORM->DONE; DONE->IDLE unconditionally.
REQ-011 start SHALL be ignored in every state except IDLE, and operands SHALL NOT change while busy.
REQ-012 PREP SHALL compute:
  - sign = number1[31] ^ number2[31];
  - 10-bit signed exponent e = ea - eb + 127;
  - mantissas {1, frac}.
REQ-013 DIVIDE SHALL run restoring division, one quotient bit per cycle, producing Q[26:0] with Q[26] of weight 2^0.
REQ-014 Sticky SHALL be the OR of the final remainder bits.
REQ-015 NORM SHALL normalise, round and write result:
  - if Q[26]=1: mantissa = Q[25:3], guard = Q[2], sticky' = Q[1] | Q[0] | sticky;
  - else: shift left one, e = e - 1;
  - round to nearest, ties to even;
  - a mantissa carry-out increments e.
REQ-016 If final e >= 255, result SHALL be signed infinity.
REQ-017 If final e <= 0, result SHALL be signed zero (flush to zero, no denormal output).
REQ-018 Denormal inputs (exp=0, frac!=0) SHALL be treated as signed zero.
REQ-019 Special cases SHALL be resolved in PREP:
  - NaN in, 0/0 or Inf/Inf: 32'h7FC00000;
  - x/0 (x non-zero, finite): signed Inf;
  - Inf/finite: signed Inf;
  - 0/non-zero or finite/Inf: signed zero.
REQ-020 Latency, with start accepted at edge k, SHALL be: normal path result written and done high after edge k+29; special path after edge k+2.
REQ-021 done and busy SHALL NOT be high together except in the DONE cycle (busy high there).
REQ-022 A new start SHALL be accepted in the cycle immediately after DONE (back-to-back ops).

Reset
REQ-023 rst SHALL force IDLE, with busy=0, done=0, result=32'h0 and all datapath registers cleared.
REQ-024 rst SHALL take priority over start in the same cycle.
REQ-025 rst mid-operation SHALL abort with no done pulse.

Structure
REQ-026 Package fp32_pkg SHALL hold:
  - field widths (EXP_W=8, FRAC_W=23);
  - BIAS=127;
  - QUOT_W=27;
  - QNAN=32'h7FC00000 and POS_INF=32'h7F800000;
  - the state enum.
REQ-027 Sub-module mant_div_step SHALL implement one restoring iteration: 25-bit remainder and divisor in, next remainder and quotient bit out, combinational.
REQ-028 FSM, counter, exponent and rounding logic SHALL live in fp32_divider_seq.

Verification
REQ-029 6.0/2.0: 32'h40C00000 / 32'h40000000 -> result 32'h40400000, done exactly 29 cycles after start.
REQ-030 1.0/3.0: 32'h3F800000 / 32'h40400000 -> 32'h3EAAAAAB (rounding up).
REQ-031 Divide by zero: 32'hBF800000 / 32'h00000000 -> 32'hFF800000, done 2 cycles after start; 0/0 -> 32'h7FC00000.
REQ-032 Overflow/underflow:
  - 32'h7F000000 / 32'h3E800000 -> 32'h7F800000;
  - 32'h00800000 / 32'h40000000 -> 32'h00000000.
REQ-033 Assert rst 10 cycles after start -> no done pulse, busy=0, result=0 next cycle; a start pulsed while busy -> ignored, single done observed.
REQ-034 Back-to-back: start in cycle after done with 32'h41200000 / 32'h40A00000 -> 32'h40000000.
